// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: WIDTH data bits plus one tail cycle on dat_en, then GAP_CYCLES idle.
// A one-word holding register accepts the next word while the current one shifts.
module p2s_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             dat_en,
  output logic             tx_done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // IDLE: waiting for a word | SHIFT: data bits on so | TAIL: frame end cycle | GAP: dat_en low spacing
  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, GAP} state_t;

  state_t           state, state_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0]    gap_cnt, gap_cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic             so_nx, dat_en_nx, tx_done_nx;
  logic             accept, load;
  logic [WIDTH-1:0] load_word;

  // The shifter keeps the next bit to send at the end selected by MSB_FIRST.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign pi_ready  = !hold_full;
  assign accept    = pi_valid && !hold_full;
  assign busy      = (state != IDLE) || hold_full;
  assign load_word = hold_full ? hold : pi_data;

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    gap_cnt_nx   = gap_cnt;
    shreg_nx     = shreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    so_nx        = 1'b0;
    dat_en_nx    = 1'b0;
    tx_done_nx   = 1'b0;
    load         = 1'b0;

    if (accept && (state != IDLE)) begin
      hold_nx      = pi_data;
      hold_full_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full || accept) load = 1'b1;
      end
      SHIFT: begin
        dat_en_nx  = 1'b1;
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) begin
          state_nx   = TAIL;
          tx_done_nx = 1'b1;
        end else begin
          so_nx    = first_bit(shreg);
          shreg_nx = advance(shreg);
        end
      end
      TAIL: begin
        if (GAP_CYCLES > 0) begin
          state_nx   = GAP;
          gap_cnt_nx = '0;
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) load = 1'b1;
          else           state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Loading a word drains the hold register when it was the source.
    if (load) begin
      state_nx   = SHIFT;
      so_nx      = first_bit(load_word);
      shreg_nx   = advance(load_word);
      dat_en_nx  = 1'b1;
      bit_cnt_nx = '0;
      if (hold_full) hold_full_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      so        <= 1'b0;
      dat_en    <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      shreg     <= shreg_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      so        <= so_nx;
      dat_en    <= dat_en_nx;
      tx_done   <= tx_done_nx;
    end
  end

endmodule
